// File: rtl/seq_barrel_shifter.sv
// Multi-cycle barrel shifter: accepts a job via valid/ready, shifts one bit per clock,
// and presents the result through a second valid/ready handshake.
module seq_barrel_shifter #(
   parameter int IWIDTH = 4,
   parameter int SWIDTH = 2
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              IN_VALID,
   output logic              IN_READY,
   input  logic              BS_DIR,
   input  logic [SWIDTH-1:0] BS_AMT,
   input  logic [IWIDTH-1:0] D_IN,
   output logic              OUT_VALID,
   input  logic              OUT_READY,
   output logic [IWIDTH-1:0] D_OUT,
   output logic              BUSY
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_t;

   localparam logic [SWIDTH-1:0] CNT_ZERO = SWIDTH'(0);
   localparam logic [SWIDTH-1:0] CNT_ONE  = SWIDTH'(1);

   state_t              state_q, state_d;
   logic [IWIDTH-1:0]   sreg_q,  sreg_d;
   logic [SWIDTH-1:0]   cnt_q,   cnt_d;
   logic                dir_q,   dir_d;

   // Right shifts are arithmetic so results agree with the combinational shifter.
   function automatic logic [IWIDTH-1:0] shift_one(input logic [IWIDTH-1:0] val,
                                                   input logic             right);
      logic [IWIDTH-1:0] res;
      if (right) begin
         res = {val[IWIDTH-1], val[IWIDTH-1:1]};
      end else begin
         res = {val[IWIDTH-2:0], 1'b0};
      end
      return res;
   endfunction

   // Next-state and datapath update.
   always_comb begin
      state_d = state_q;
      sreg_d  = sreg_q;
      cnt_d   = cnt_q;
      dir_d   = dir_q;
      case (state_q)
         ST_IDLE: begin
            if (IN_VALID) begin
               sreg_d = D_IN;
               dir_d  = BS_DIR;
               cnt_d  = BS_AMT;
               if (BS_AMT != CNT_ZERO) begin
                  state_d = ST_SHIFT;
               end else begin
                  state_d = ST_DONE;
               end
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_SHIFT: begin
            sreg_d = shift_one(sreg_q, dir_q);
            cnt_d  = cnt_q - CNT_ONE;
            if (cnt_q == CNT_ONE) begin
               state_d = ST_DONE;
            end else begin
               state_d = ST_SHIFT;
            end
         end
         ST_DONE: begin
            if (OUT_READY) begin
               state_d = ST_IDLE;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d = ST_IDLE;
            sreg_d  = {IWIDTH{1'b0}};
            cnt_d   = CNT_ZERO;
            dir_d   = 1'b0;
         end
      endcase
   end

   // State and datapath registers; reset discards any job in flight.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state_q <= ST_IDLE;
         sreg_q  <= {IWIDTH{1'b0}};
         cnt_q   <= CNT_ZERO;
         dir_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         sreg_q  <= sreg_d;
         cnt_q   <= cnt_d;
         dir_q   <= dir_d;
      end
   end

   assign IN_READY  = (state_q == ST_IDLE);
   assign OUT_VALID = (state_q == ST_DONE);
   assign BUSY      = (state_q != ST_IDLE);
   assign D_OUT     = sreg_q;

endmodule

// File: tb/tb_seq_barrel_shifter.sv
// Directed self-checking bench for seq_barrel_shifter (IWIDTH=4, SWIDTH=2).
module tb_seq_barrel_shifter;

   logic       clk;
   logic       rst;
   logic       in_valid;
   logic       in_ready;
   logic       bs_dir;
   logic [1:0] bs_amt;
   logic [3:0] d_in;
   logic       out_valid;
   logic       out_ready;
   logic [3:0] d_out;
   logic       busy;

   int checks;
   int failures;

   seq_barrel_shifter #(.IWIDTH(4), .SWIDTH(2)) dut (
      .CLK       (clk),
      .RST       (rst),
      .IN_VALID  (in_valid),
      .IN_READY  (in_ready),
      .BS_DIR    (bs_dir),
      .BS_AMT    (bs_amt),
      .D_IN      (d_in),
      .OUT_VALID (out_valid),
      .OUT_READY (out_ready),
      .D_OUT     (d_out),
      .BUSY      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // One full job: accept, shift latency, result, transfer. Inputs are scrambled after accept.
   task automatic run_job(input string tag, input logic d, input logic [1:0] a,
                          input logic [3:0] din, input logic [3:0] exp);
      @(negedge clk);
      check_val({tag, "_rdy"}, 32'(in_ready), 32'd1);
      bs_dir   = d;
      bs_amt   = a;
      d_in     = din;
      in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      bs_dir   = ~d;
      bs_amt   = ~a;
      d_in     = ~din;
      for (int i = 0; i < int'(a); i++) begin
         check_val({tag, "_nv"}, 32'(out_valid), 32'd0);
         @(posedge clk); #1;
      end
      check_val({tag, "_ov"}, 32'(out_valid), 32'd1);
      check_val({tag, "_busy"}, 32'(busy), 32'd1);
      check_val({tag, "_dout"}, 32'(d_out), 32'(exp));
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val({tag, "_idle_rdy"}, 32'(in_ready), 32'd1);
      check_val({tag, "_idle_ov"}, 32'(out_valid), 32'd0);
   endtask

   // {dir, amt, din, expected}
   logic [10:0] jobs [0:8];

   initial begin
      checks    = 0;
      failures  = 0;
      rst       = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      bs_dir    = 1'b0;
      bs_amt    = 2'b00;
      d_in      = 4'b0000;

      jobs[0] = {1'b0, 2'b11, 4'b1111, 4'b1000};
      jobs[1] = {1'b1, 2'b01, 4'b1011, 4'b1101};
      jobs[2] = {1'b1, 2'b10, 4'b1011, 4'b1110};
      jobs[3] = {1'b1, 2'b11, 4'b1011, 4'b1111};
      jobs[4] = {1'b1, 2'b00, 4'b1011, 4'b1011};
      jobs[5] = {1'b1, 2'b01, 4'b0010, 4'b0001};
      jobs[6] = {1'b1, 2'b10, 4'b0010, 4'b0000};
      jobs[7] = {1'b1, 2'b11, 4'b0010, 4'b0000};
      jobs[8] = {1'b0, 2'b10, 4'b0101, 4'b0100};

      // Asynchronous reset between edges
      #3 rst = 1'b1;
      #1;
      check_val("rst_ov", 32'(out_valid), 32'd0);
      check_val("rst_busy", 32'(busy), 32'd0);
      check_val("rst_rdy", 32'(in_ready), 32'd1);
      check_val("rst_dout", 32'(d_out), 32'd0);
      @(negedge clk);
      @(negedge clk);
      rst = 1'b0;

      for (int j = 0; j < 9; j++) begin
         run_job($sformatf("job%0d", j), jobs[j][10], jobs[j][9:8], jobs[j][7:4], jobs[j][3:0]);
      end

      // Backpressure with a second job held pending
      @(negedge clk);
      bs_dir = 1'b1; bs_amt = 2'b11; d_in = 4'b1011; in_valid = 1'b1;
      @(posedge clk); #1;
      bs_dir = 1'b0; bs_amt = 2'b10; d_in = 4'b0011;
      for (int i = 0; i < 3; i++) begin
         check_val("bp_shift_nv", 32'(out_valid), 32'd0);
         check_val("bp_shift_rdy", 32'(in_ready), 32'd0);
         @(posedge clk); #1;
      end
      for (int i = 0; i < 10; i++) begin
         check_val("bp_hold_ov", 32'(out_valid), 32'd1);
         check_val("bp_hold_dout", 32'(d_out), 32'hF);
         @(posedge clk); #1;
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("bp_xfer_rdy", 32'(in_ready), 32'd1);
      check_val("bp_xfer_ov", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      in_valid = 1'b0;
      check_val("bp_b_acc_busy", 32'(busy), 32'd1);
      check_val("bp_b_acc_nv", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_val("bp_b_mid_nv", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      check_val("bp_b_ov", 32'(out_valid), 32'd1);
      check_val("bp_b_dout", 32'(d_out), 32'hC);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
      check_val("bp_b_idle", 32'(in_ready), 32'd1);

      // Reset during the second shift cycle discards the job
      @(negedge clk);
      bs_dir = 1'b0; bs_amt = 2'b11; d_in = 4'b1111; in_valid = 1'b1;
      @(posedge clk); #1;
      in_valid = 1'b0;
      @(posedge clk); #3;
      check_val("mid_pre_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      #1;
      check_val("mid_rst_ov", 32'(out_valid), 32'd0);
      check_val("mid_rst_busy", 32'(busy), 32'd0);
      check_val("mid_rst_rdy", 32'(in_ready), 32'd1);
      check_val("mid_rst_dout", 32'(d_out), 32'd0);
      @(negedge clk);
      rst = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(posedge clk); #1;
         check_val("mid_no_ov", 32'(out_valid), 32'd0);
      end
      run_job("post_rst", 1'b0, 2'b01, 4'b0110, 4'b1100);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
